sha256_w_expander_stream: RTL and testbench
===========================================

Name: sha256_w_expander_stream

Overview:
- Parametrised successor to the single-word, fixed-window W-schedule pipeline stage.
- Accepts one 512-bit padded block (W0..W15) and streams W16..W_LAST at WORDS_PER_CYCLE words per beat over a valid/ready output.
- Keeps a 16-word sliding window internally. Supports early termination at W_LAST (e.g. 58 or 60) for compact double-SHA256 pipelines.
- Sits between the block formatter and the round pipeline.

Parameters:
- WORDS_PER_CYCLE, 1: W words produced per output beat; legal values 1, 2, 4.
- W_LAST, 63: index of the final W word produced.
  - Legal range 16..63.
  - (W_LAST-15) must be a multiple of WORDS_PER_CYCLE; otherwise elaboration fails.
- IDX_W, 6: width of the word-index output.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high; clears all state.
- flush  input  1  synchronous abort; returns to IDLE and drops the current block.
- in_valid  input  1  block_in is valid.
- in_ready  output  1  block accepted on the cycle where in_valid && in_ready.
- block_in  input  512  W0 in [511:480] through W15 in [31:0].
- out_valid  output  1  w_out holds a valid beat.
- out_ready  input  1  downstream accepts the beat.
- w_out  output  32*WORDS_PER_CYCLE  word w_idx+k in bits [32k+31:32k].
- w_idx  output  IDX_W  index of the lowest word in the beat.
- out_last  output  1  the beat contains W_LAST.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST high): state=IDLE, window=0, out_valid=0, w_out=0, w_idx=0, out_last=0, in_ready=1, busy=0. Reset takes effect immediately, including mid-block; no partial beat survives.
- States:
  - IDLE: in_ready=1. On accept, load the window from block_in, set next_idx=16, go to EXPAND.
  - EXPAND: in_ready=0. Produce beats as described below.
  - DRAIN: in_ready=0. Holds the final beat until it is consumed, then goes to IDLE.
- Advance condition: adv = !out_valid || out_ready.
- Beat generation, in EXPAND when adv is true:
  - Compute N=WORDS_PER_CYCLE new words.
  - Each word: W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], mod 2^32.
    - sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3.
    - sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - Within a beat, words chain combinationally: word t+2 may use word t from the same beat.
- Register update on an EXPAND beat:
  - w_out <= new words; w_idx <= next_idx; out_valid <= 1.
  - window shifts left by N words; next_idx += N.
  - out_last <= (next_idx+N-1 == W_LAST); if set, go to DRAIN.
- Holding: when out_valid && !out_ready, w_out, w_idx, out_last and the window hold stable. Advance is stall-safe; no word is lost or duplicated.
- DRAIN: if out_ready, clear out_valid and out_last and go to IDLE. The cycle after the last handshake has in_ready=1, giving one bubble between blocks.
- Latency: block accepted at edge T; first beat valid after edge T+1.
- Throughput: (W_LAST-15)/N beats per block, plus 1 idle cycle.
- flush:
  - Takes priority over all other transitions.
  - Next cycle: out_valid=0, out_last=0, state=IDLE.
  - The window keeps stale data, which is ignored.
  - flush together with in_valid in IDLE: flush wins; the block is not accepted.
- in_valid is ignored while busy. Upstream must hold block_in until in_ready is seen.
- w_idx wraps never; the maximum value is W_LAST-N+1.

Decomposition:
- Shared package sha256_pkg holds:
  - WORD_W=32.
  - Functions sigma0_256 and sigma1_256.
  - Constants W_FIRST=16 and W_MAX=63.
  - State-encoding localparams IDLE/EXPAND/DRAIN.
- Sub-module sha256_w_step: combinational, four 32-bit inputs (w_m2, w_m7, w_m15, w_m16), one 32-bit output. Instantiated N times in a generate chain.

Test Plan:
- N=1, W_LAST=63, "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> 48 beats; beat0 w_idx=16 w_out=0x61626380; beat1 w_idx=17 w_out=0x000F0000; out_last only on w_idx=63.
- N=2, W_LAST=57 (42 words), same block -> 21 beats; beat0 w_out={0x000F0000,0x61626380}; out_last on w_idx=56; next block accepted one cycle after the last handshake.
- N=4, random block, out_ready toggled randomly -> all words match the software model; w_out stable while stalled; no gaps or repeats in w_idx.
- All-zero block, N=1 -> 48 beats, all w_out=0x00000000, busy high throughout.
- RST asserted mid-block at w_idx=30 -> out_valid=0, busy=0, in_ready=1 immediately; a fresh block then starts again at w_idx=16.
- flush asserted while stalled (out_valid=1, out_ready=0) together with in_valid -> out_valid=0 next cycle; the block is not accepted that cycle and is accepted the following cycle.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule definitions: word width, index bounds,
// expander state encoding and the small-sigma functions.
package sha256_pkg;

  localparam int WORD_W    = 32;
  localparam int WIN_WORDS = 16;
  localparam int W_FIRST   = 16;
  localparam int W_MAX     = 63;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] sigma0_256(input logic [WORD_W-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sigma1_256(input logic [WORD_W-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

endpackage

// File: rtl/sha256_w_step.sv
// One message-schedule step: W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
module sha256_w_step
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w_m2,
  input  logic [WORD_W-1:0] w_m7,
  input  logic [WORD_W-1:0] w_m15,
  input  logic [WORD_W-1:0] w_m16,
  output logic [WORD_W-1:0] w_new
);

  assign w_new = sigma1_256(w_m2) + w_m7 + sigma0_256(w_m15) + w_m16;

endmodule

// File: rtl/sha256_w_expander_stream.sv
// Streams W16..W_LAST of one padded block, WORDS_PER_CYCLE words per beat,
// from a 16-word sliding window over a valid/ready output.
module sha256_w_expander_stream
  import sha256_pkg::*;
#(
  parameter int WORDS_PER_CYCLE = 1,
  parameter int W_LAST          = 63,
  parameter int IDX_W           = 6
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic                              flush,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [511:0]                      block_in,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_W*WORDS_PER_CYCLE-1:0] w_out,
  output logic [IDX_W-1:0]                  w_idx,
  output logic                              out_last,
  output logic                              busy
);

  localparam int N    = WORDS_PER_CYCLE;
  localparam int IDX1 = IDX_W + 1;

  if (!(N == 1 || N == 2 || N == 4)) begin : g_bad_words_per_cycle
    $error("WORDS_PER_CYCLE must be 1, 2 or 4");
  end
  if (W_LAST < W_FIRST || W_LAST > W_MAX) begin : g_bad_w_last
    $error("W_LAST must lie in 16..63");
  end
  if (((W_LAST - 15) % N) != 0) begin : g_bad_w_last_align
    $error("W_LAST-15 must be a multiple of WORDS_PER_CYCLE");
  end

  state_e                    state_q, state_d;
  logic [WORD_W-1:0]         win_q [WIN_WORDS];
  logic [WORD_W-1:0]         win_d [WIN_WORDS];
  logic [WORD_W-1:0]         ext_s [WIN_WORDS+N];
  logic [WORD_W*N-1:0]       beat_s;
  logic [IDX_W-1:0]          next_idx_q, next_idx_d;
  logic [IDX_W-1:0]          w_idx_q, w_idx_d;
  logic [WORD_W*N-1:0]       w_out_q, w_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic                      adv_s;
  logic                      last_s;
  logic [IDX1-1:0]           top_idx_s;

  // ext_s[0..15] is the window W[next-16..next-1]; later entries chain new words.
  for (genvar i = 0; i < WIN_WORDS; i++) begin : g_win
    assign ext_s[i] = win_q[i];
  end

  for (genvar k = 0; k < N; k++) begin : g_step
    sha256_w_step u_step (
      .w_m2  (ext_s[14+k]),
      .w_m7  (ext_s[9+k]),
      .w_m15 (ext_s[1+k]),
      .w_m16 (ext_s[k]),
      .w_new (ext_s[WIN_WORDS+k])
    );
    assign beat_s[WORD_W*k +: WORD_W] = ext_s[WIN_WORDS+k];
  end

  assign adv_s     = !out_valid_q || out_ready;
  assign top_idx_s = {1'b0, next_idx_q} + IDX1'(N - 1);
  assign last_s    = (top_idx_s == IDX1'(W_LAST));

  // Next-state and datapath selection; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    next_idx_d  = next_idx_q;
    w_idx_d     = w_idx_q;
    w_out_d     = w_out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < WIN_WORDS; i++) begin
              win_d[i] = block_in[WORD_W*(WIN_WORDS-1-i) +: WORD_W];
            end
            next_idx_d = IDX_W'(W_FIRST);
            state_d    = EXPAND;
          end else begin
            state_d = IDLE;
          end
        end
        EXPAND: begin
          if (adv_s) begin
            w_out_d     = beat_s;
            w_idx_d     = next_idx_q;
            out_valid_d = 1'b1;
            out_last_d  = last_s;
            next_idx_d  = next_idx_q + IDX_W'(N);
            for (int i = 0; i < WIN_WORDS; i++) begin
              win_d[i] = ext_s[i+N];
            end
            state_d = last_s ? DRAIN : EXPAND;
          end else begin
            state_d = EXPAND;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      endcase
    end
  end

  // State, window and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      next_idx_q  <= '0;
      w_idx_q     <= '0;
      w_out_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < WIN_WORDS; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      next_idx_q  <= next_idx_d;
      w_idx_q     <= w_idx_d;
      w_out_q     <= w_out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      for (int i = 0; i < WIN_WORDS; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign w_out     = w_out_q;
  assign w_idx     = w_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_sha256_w_expander_stream.sv
// Directed bench for the W-schedule expander: three instances (1, 2 and 4
// words per beat) checked against a reference schedule and known constants.
module tb_sha256_w_expander_stream;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int            sel;
  logic          tb_in_valid, tb_out_ready, tb_flush;
  logic [511:0]  tb_block;
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [31:0]   model_w [64];

  logic          ir1, ov1, ol1, bz1;
  logic [31:0]   wo1;
  logic [5:0]    wi1;
  logic          ir2, ov2, ol2, bz2;
  logic [63:0]   wo2;
  logic [5:0]    wi2;
  logic          ir4, ov4, ol4, bz4;
  logic [127:0]  wo4;
  logic [5:0]    wi4;

  logic          o_valid, o_in_ready, o_last, o_busy;
  logic [127:0]  o_w_out;
  logic [5:0]    o_w_idx;

  assign o_valid    = (sel == 0) ? ov1 : (sel == 1) ? ov2 : ov4;
  assign o_in_ready = (sel == 0) ? ir1 : (sel == 1) ? ir2 : ir4;
  assign o_last     = (sel == 0) ? ol1 : (sel == 1) ? ol2 : ol4;
  assign o_busy     = (sel == 0) ? bz1 : (sel == 1) ? bz2 : bz4;
  assign o_w_out    = (sel == 0) ? {96'h0, wo1} : (sel == 1) ? {64'h0, wo2} : wo4;
  assign o_w_idx    = (sel == 0) ? wi1 : (sel == 1) ? wi2 : wi4;

  sha256_w_expander_stream #(.WORDS_PER_CYCLE(1), .W_LAST(63), .IDX_W(6)) u_dut1 (
    .CLK(clk), .RST(rst), .flush(tb_flush && sel == 0),
    .in_valid(tb_in_valid && sel == 0), .in_ready(ir1), .block_in(tb_block),
    .out_valid(ov1), .out_ready(tb_out_ready || sel != 0), .w_out(wo1),
    .w_idx(wi1), .out_last(ol1), .busy(bz1)
  );

  sha256_w_expander_stream #(.WORDS_PER_CYCLE(2), .W_LAST(57), .IDX_W(6)) u_dut2 (
    .CLK(clk), .RST(rst), .flush(tb_flush && sel == 1),
    .in_valid(tb_in_valid && sel == 1), .in_ready(ir2), .block_in(tb_block),
    .out_valid(ov2), .out_ready(tb_out_ready || sel != 1), .w_out(wo2),
    .w_idx(wi2), .out_last(ol2), .busy(bz2)
  );

  sha256_w_expander_stream #(.WORDS_PER_CYCLE(4), .W_LAST(63), .IDX_W(6)) u_dut4 (
    .CLK(clk), .RST(rst), .flush(tb_flush && sel == 2),
    .in_valid(tb_in_valid && sel == 2), .in_ready(ir4), .block_in(tb_block),
    .out_valid(ov4), .out_ready(tb_out_ready || sel != 2), .w_out(wo4),
    .w_idx(wi4), .out_last(ol4), .busy(bz4)
  );

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ref_s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  task automatic compute_model(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) model_w[i] = blk[511-32*i -: 32];
    for (int t = 16; t < 64; t++)
      model_w[t] = ref_s1(model_w[t-2]) + model_w[t-7] + ref_s0(model_w[t-15]) + model_w[t-16];
  endtask

  // Called at a negedge with the selected instance idle; returns at the negedge after drain.
  task automatic run_block(input logic [511:0] blk, input int n, input int wlast,
                           input bit rnd, input bit abc);
    int exp_idx, beats, nbeats;
    bit stalled;
    logic [127:0] expv, prev_w;
    logic [5:0] prev_i;
    compute_model(blk);
    nbeats = (wlast - 15) / n;
    exp_idx = 16; beats = 0; stalled = 1'b0;
    prev_w = '0; prev_i = '0;
    tb_block = blk; tb_in_valid = 1'b1; tb_out_ready = 1'b1;
    check_eq("in_ready_before_accept", o_in_ready, 1);
    @(negedge clk);
    tb_in_valid = 1'b0;
    check_eq("latency_busy", o_busy, 1);
    check_eq("latency_no_beat_yet", o_valid, 0);
    for (int cyc = 0; cyc < 1000 && beats < nbeats; cyc++) begin
      @(negedge clk);
      if (rnd) tb_out_ready = 1'($urandom_range(0, 1));
      if (stalled) begin
        check_eq("stall_w_out_stable", o_w_out, prev_w);
        check_eq("stall_w_idx_stable", o_w_idx, prev_i);
      end
      if (o_valid && tb_out_ready) begin
        expv = '0;
        for (int k = 0; k < n; k++) expv[32*k +: 32] = model_w[exp_idx+k];
        check_eq("beat_w_idx", o_w_idx, exp_idx);
        check_eq("beat_w_out", o_w_out, expv);
        check_eq("beat_out_last", o_last, (exp_idx + n - 1) == wlast);
        check_eq("beat_busy", o_busy, 1);
        if (abc && beats == 0)
          check_eq("abc_beat0", o_w_out, (n == 1) ? 128'h61626380 : 128'h000F0000_61626380);
        if (abc && n == 1 && beats == 1)
          check_eq("abc_w17", o_w_out, 128'h000F0000);
        beats++;
        exp_idx += n;
      end
      stalled = o_valid && !tb_out_ready;
      prev_w = o_w_out;
      prev_i = o_w_idx;
    end
    check_eq("beat_count", beats, nbeats);
    tb_out_ready = 1'b1;
    @(negedge clk);
    check_eq("bubble_out_valid", o_valid, 0);
    check_eq("bubble_out_last", o_last, 0);
    check_eq("bubble_in_ready", o_in_ready, 1);
    check_eq("bubble_busy", o_busy, 0);
  endtask

  initial begin
    logic [511:0] rblk;
    bit found;
    rst = 1'b1; sel = 0;
    tb_in_valid = 1'b0; tb_out_ready = 1'b1; tb_flush = 1'b0; tb_block = '0;
    #1;
    check_eq("rst_out_valid", {ov1, ov2, ov4}, 0);
    check_eq("rst_in_ready", {ir1, ir2, ir4}, 3'b111);
    check_eq("rst_busy", {bz1, bz2, bz4}, 0);
    check_eq("rst_out_last", {ol1, ol2, ol4}, 0);
    check_eq("rst_w_out", {wo1, wo2, wo4}, 0);
    check_eq("rst_w_idx", {wi1, wi2, wi4}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    sel = 0;
    run_block(ABC_BLK, 1, 63, 1'b0, 1'b1);
    run_block('0, 1, 63, 1'b0, 1'b0);

    sel = 1;
    run_block(ABC_BLK, 2, 57, 1'b0, 1'b1);
    run_block(ABC_BLK, 2, 57, 1'b0, 1'b1);

    sel = 2;
    for (int i = 0; i < 16; i++) rblk[32*i +: 32] = $urandom;
    run_block(rblk, 4, 63, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a block.
    sel = 0;
    tb_block = ABC_BLK; tb_in_valid = 1'b1; tb_out_ready = 1'b1;
    @(negedge clk);
    tb_in_valid = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      if (o_valid && o_w_idx == 6'd30) found = 1'b1;
    end
    check_eq("rst_mid_reach_idx30", found, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_out_valid", o_valid, 0);
    check_eq("rst_mid_busy", o_busy, 0);
    check_eq("rst_mid_in_ready", o_in_ready, 1);
    check_eq("rst_mid_w_idx", o_w_idx, 0);
    @(negedge clk);
    rst = 1'b0;
    run_block(ABC_BLK, 1, 63, 1'b0, 1'b1);

    // Flush while stalled, with in_valid also high.
    tb_block = ABC_BLK; tb_out_ready = 1'b0; tb_in_valid = 1'b1;
    @(negedge clk);
    tb_in_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_pre_valid", o_valid, 1);
    tb_flush = 1'b1; tb_in_valid = 1'b1;
    @(negedge clk);
    check_eq("flush_out_valid", o_valid, 0);
    check_eq("flush_out_last", o_last, 0);
    check_eq("flush_not_accepted", o_busy, 0);
    check_eq("flush_in_ready", o_in_ready, 1);
    tb_flush = 1'b0;
    @(negedge clk);
    check_eq("flush_then_accept", o_busy, 1);
    tb_in_valid = 1'b0; tb_out_ready = 1'b1;
    @(negedge clk);
    check_eq("flush_restart_valid", o_valid, 1);
    check_eq("flush_restart_idx", o_w_idx, 16);
    check_eq("flush_restart_w", o_w_out, 128'h61626380);
    tb_flush = 1'b1;
    @(negedge clk);
    tb_flush = 1'b0;
    check_eq("flush_to_idle", o_busy, 0);

    // Flush in IDLE beats a simultaneous in_valid.
    tb_flush = 1'b1; tb_in_valid = 1'b1;
    @(negedge clk);
    check_eq("flush_idle_reject", o_busy, 0);
    tb_flush = 1'b0; tb_in_valid = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
